// File: rtl/pix_fifo.sv
// Two-pixel-per-word FIFO: 48-bit words in, 24-bit pixels out through a
// word register with a half-select, plus sticky overflow/underflow flags.
module pix_fifo #(
    parameter int DEPTH  = 256,
    parameter int ALFULL = 224
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fiforeset,
    input  logic [47:0]            di,
    input  logic                   wr,
    output logic                   fifoalfull,
    output logic [$clog2(DEPTH):0] level,
    output logic [23:0]            po,
    output logic                   pvalid,
    input  logic                   pready,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [47:0]   mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [LW-1:0] level_r;
    logic [47:0]   word_r;
    logic          wvalid_r;
    logic          hs_r;
    logic          armed_r;
    logic          ovf_r;
    logic          unf_r;
    logic          alfull_r;
    logic [23:0]   po_r;

    logic          clr_s;
    logic          full_s;
    logic          empty_s;
    logic          xfer_s;
    logic          release_s;
    logic          wr_ok_s;
    logic          we_s;
    logic          drop_s;
    logic          rd_s;
    logic          starve_s;
    logic [AW-1:0] wptr_nxt_s;
    logic [AW-1:0] rptr_nxt_s;
    logic [LW-1:0] level_nxt_s;
    logic [47:0]   word_nxt_s;
    logic          wvalid_nxt_s;
    logic          hs_nxt_s;
    logic [23:0]   po_nxt_s;

    // Handshake decode, pointer/level arithmetic and output-stage next state.
    always_comb begin
        clr_s     = !reset || fiforeset;
        full_s    = (level_r == LW'(DEPTH));
        empty_s   = (level_r == {LW{1'b0}});
        xfer_s    = wvalid_r && pready;
        release_s = xfer_s && hs_r;
        // Fullness looks only at the registered level, so a same-cycle read never frees a slot.
        wr_ok_s   = wr && !full_s;
        we_s      = wr_ok_s && !clr_s;
        drop_s    = wr && full_s;
        rd_s      = (!wvalid_r || release_s) && !empty_s;
        starve_s  = armed_r && pready && !wvalid_r;

        wptr_nxt_s = wptr_r;
        if (wr_ok_s) begin
            wptr_nxt_s = wptr_r + AW'(1);
        end else begin
            wptr_nxt_s = wptr_r;
        end

        rptr_nxt_s = rptr_r;
        if (rd_s) begin
            rptr_nxt_s = rptr_r + AW'(1);
        end else begin
            rptr_nxt_s = rptr_r;
        end

        level_nxt_s = level_r;
        case ({wr_ok_s, rd_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase

        word_nxt_s   = word_r;
        wvalid_nxt_s = wvalid_r;
        hs_nxt_s     = hs_r;
        // The array read lands straight in the word register: one-cycle read latency.
        if (rd_s) begin
            word_nxt_s   = mem_r[rptr_r];
            wvalid_nxt_s = 1'b1;
            hs_nxt_s     = 1'b0;
        end else if (release_s) begin
            wvalid_nxt_s = 1'b0;
            hs_nxt_s     = 1'b0;
        end else if (xfer_s) begin
            hs_nxt_s     = 1'b1;
        end else begin
            hs_nxt_s     = hs_r;
        end

        if (hs_nxt_s) begin
            po_nxt_s = word_nxt_s[47:24];
        end else begin
            po_nxt_s = word_nxt_s[23:0];
        end
    end

    // Storage array write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wptr_r] <= di;
        end
    end

    // Control state, output stage and sticky flags with reset/flush clear.
    always_ff @(posedge clk) begin
        if (clr_s) begin
            wptr_r   <= {AW{1'b0}};
            rptr_r   <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            word_r   <= 48'h0;
            wvalid_r <= 1'b0;
            hs_r     <= 1'b0;
            armed_r  <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            alfull_r <= 1'b0;
            po_r     <= 24'h0;
        end else begin
            wptr_r   <= wptr_nxt_s;
            rptr_r   <= rptr_nxt_s;
            level_r  <= level_nxt_s;
            word_r   <= word_nxt_s;
            wvalid_r <= wvalid_nxt_s;
            hs_r     <= hs_nxt_s;
            armed_r  <= armed_r | wvalid_r;
            ovf_r    <= ovf_r | drop_s;
            unf_r    <= unf_r | starve_s;
            // Registered from the next level so it always equals the level compare.
            alfull_r <= (level_nxt_s >= LW'(ALFULL));
            po_r     <= po_nxt_s;
        end
    end

    assign level      = level_r;
    assign fifoalfull = alfull_r;
    assign pvalid     = wvalid_r;
    assign po         = po_r;
    assign overflow   = ovf_r;
    assign underflow  = unf_r;

endmodule

// File: tb/tb_pix_fifo.sv
// Bench for pix_fifo: cycle vector table, hand sequences for fill/flush/latency,
// and a long random run checked by a pixel-queue reference model.
module tb_pix_fifo;

    localparam int DEPTH  = 256;
    localparam int ALFULL = 224;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fiforeset = 1'b0;
    logic        wr = 1'b0;
    logic        pready = 1'b0;
    logic [47:0] di = 48'h0;
    logic        fifoalfull;
    logic        pvalid;
    logic        overflow;
    logic        underflow;
    logic [8:0]  level;
    logic [23:0] po;

    int total_cnt = 0;
    int pass_cnt  = 0;

    pix_fifo #(.DEPTH(DEPTH), .ALFULL(ALFULL)) dut (
        .clk(clk), .reset(reset), .fiforeset(fiforeset), .di(di), .wr(wr),
        .fifoalfull(fifoalfull), .level(level), .po(po), .pvalid(pvalid),
        .pready(pready), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pixels owed to the consumer in write order, and whole words held.
    logic [23:0] pq[$];
    int          words_m = 0;
    bit          mon_en = 1'b0;
    logic        stall_p = 1'b0;
    logic [23:0] po_p = 24'h0;
    logic [23:0] exp_px;
    int          exp_lv;

    // Mid-cycle monitor: checks post-edge state, then applies this cycle's inputs to the model.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_lv = words_m - (pvalid ? 1 : 0);
            chk("level_vs_model", 48'(level), 48'(exp_lv));
            if (stall_p) begin
                chk("stall_pvalid", 48'(pvalid), 48'(1));
                chk("stall_po", 48'(po), 48'(po_p));
            end
            if (pvalid === 1'b1 && pready === 1'b1) begin
                total_cnt++;
                if (pq.size() == 0) begin
                    $display("FAIL xfer_order: actual=%0h required=<nothing pending>", po);
                end else begin
                    exp_px = pq.pop_front();
                    if (po === exp_px) pass_cnt++;
                    else $display("FAIL xfer_order: actual=%0h required=%0h", po, exp_px);
                    if (pq.size() % 2 == 0) words_m--;
                end
            end
            stall_p = pvalid && !pready && reset && !fiforeset;
            po_p    = po;
            if (!reset || fiforeset) begin
                pq.delete();
                words_m = 0;
            end else if (wr && level < DEPTH) begin
                pq.push_back(di[23:0]);
                pq.push_back(di[47:24]);
                words_m++;
            end
        end
    end

    typedef struct {
        logic        rst_n, flush, wr, rdy;
        logic [47:0] di;
        logic        pv;
        logic [23:0] po;
        logic        chkpo;
        logic [8:0]  lv;
        logic        ovf, unf;
    } vec_t;

    vec_t        vt[18];
    logic [47:0] w4[4];
    logic [47:0] xw;
    logic [23:0] px;
    int          written;
    int          exp_l;
    bit          done;

    task automatic drain(input string name);
        wr = 1'b0;
        pready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (pvalid == 1'b0 && level == 9'd0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 48'(done), 48'(1));
        chk({name, "_model_empty"}, 48'(pq.size()), 48'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst  fl   wr   rdy  di                  pv   po          cp   lv     ovf  unf
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 48'h0,              1'b0, 24'h0,      1'b1, 9'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 48'h0,              1'b0, 24'h0,      1'b1, 9'd0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 48'hBBBBBB_AAAAAA,  1'b0, 24'h0,      1'b0, 9'd1, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b1, 24'hAAAAAA, 1'b1, 9'd0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b1, 24'hBBBBBB, 1'b1, 9'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b0, 24'h0,      1'b0, 9'd0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b0, 24'h0,      1'b0, 9'd0, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 48'h999999_888888,  1'b0, 24'h0,      1'b1, 9'd0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 48'h222222_111111,  1'b0, 24'h0,      1'b0, 9'd1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 48'h444444_333333,  1'b1, 24'h111111, 1'b1, 9'd1, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 48'h0,              1'b1, 24'h111111, 1'b1, 9'd1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b1, 24'h222222, 1'b1, 9'd1, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b1, 24'h333333, 1'b1, 9'd0, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b1, 24'h444444, 1'b1, 9'd0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 48'h0,              1'b1, 24'h444444, 1'b1, 9'd0, 1'b0, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b0, 24'h0,      1'b0, 9'd0, 1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 48'h777777_666666,  1'b0, 24'h0,      1'b1, 9'd0, 1'b0, 1'b0};
        vt[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 48'h0,              1'b0, 24'h0,      1'b1, 9'd0, 1'b0, 1'b0};

        reset = 1'b0;
        step();
        step();
        mon_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            reset     = vt[i].rst_n;
            fiforeset = vt[i].flush;
            wr        = vt[i].wr;
            pready    = vt[i].rdy;
            di        = vt[i].di;
            step();
            chk($sformatf("vec%0d_pvalid", i), 48'(pvalid), 48'(vt[i].pv));
            if (vt[i].chkpo) chk($sformatf("vec%0d_po", i), 48'(po), 48'(vt[i].po));
            chk($sformatf("vec%0d_level", i), 48'(level), 48'(vt[i].lv));
            chk($sformatf("vec%0d_overflow", i), 48'(overflow), 48'(vt[i].ovf));
            chk($sformatf("vec%0d_underflow", i), 48'(underflow), 48'(vt[i].unf));
            chk($sformatf("vec%0d_alfull", i), 48'(fifoalfull), 48'(0));
        end
        fiforeset = 1'b0;
        reset = 1'b1;

        // Fill with no consumer; the first word sits in the output stage, outside level.
        pready = 1'b0;
        for (int k = 1; k <= DEPTH + 2; k++) begin
            wr = 1'b1;
            di = {24'(k) | 24'h800000, 24'(k)};
            step();
            exp_l = (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
            chk($sformatf("fill%0d_level", k), 48'(level), 48'(exp_l));
            chk($sformatf("fill%0d_alfull", k), 48'(fifoalfull), 48'(exp_l >= ALFULL));
            chk($sformatf("fill%0d_overflow", k), 48'(overflow), 48'(k >= DEPTH + 2));
        end

        // Full with writes and reads every cycle: level may never exceed DEPTH.
        pready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr = 1'b1;
            di = {24'(k) | 24'h400000, 24'(k) | 24'h200000};
            step();
            chk($sformatf("fullrw%0d_level_band", k), 48'(level >= 9'd255 && level <= 9'd256), 48'(1));
        end
        drain("fullrw_drain");
        step();
        step();
        chk("fullrw_underflow", 48'(underflow), 48'(1));
        chk("fullrw_overflow_sticky", 48'(overflow), 48'(1));

        // Flush mid-stream with writes held high.
        pready = 1'b0;
        for (int k = 0; k < 101; k++) begin
            wr = 1'b1;
            di = {24'(k) | 24'h100000, 24'(k)};
            step();
        end
        wr = 1'b0;
        chk("preflush_level", 48'(level), 48'(100));
        chk("preflush_flags", 48'({overflow, underflow}), 48'(3));
        for (int k = 0; k < 3; k++) begin
            fiforeset = 1'b1;
            wr = 1'b1;
            pready = 1'b1;
            di = 48'hDEAD00_BEEF00 | 48'(k);
            step();
            chk($sformatf("flush%0d_level", k), 48'(level), 48'(0));
            chk($sformatf("flush%0d_pvalid", k), 48'(pvalid), 48'(0));
            chk($sformatf("flush%0d_flags", k), 48'({overflow, underflow, fifoalfull}), 48'(0));
        end
        fiforeset = 1'b0;
        pready = 1'b0;
        wr = 1'b1;
        xw = 48'h5A5A5A_C3C3C3;
        di = xw;
        step();
        wr = 1'b0;
        chk("postflush_n1_pvalid", 48'(pvalid), 48'(0));
        chk("postflush_n1_level", 48'(level), 48'(1));
        step();
        chk("postflush_n2_pvalid", 48'(pvalid), 48'(1));
        chk("postflush_n2_po", 48'(po), 48'(xw[23:0]));
        drain("postflush_drain");

        // Four-word stream after a full reset, then starve the consumer.
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) w4[i] = {24'($urandom), 24'($urandom)};
        for (int c = 0; c < 12; c++) begin
            wr = (c < 4);
            di = (c < 4) ? w4[c] : 48'h0;
            pready = 1'b1;
            step();
            chk($sformatf("stream%0d_pvalid", c), 48'(pvalid), 48'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) begin
                xw = w4[(c - 1) / 2];
                px = ((c - 1) % 2 == 0) ? xw[23:0] : xw[47:24];
                chk($sformatf("stream%0d_po", c), 48'(po), 48'(px));
            end
            chk($sformatf("stream%0d_underflow", c), 48'(underflow), 48'(c >= 10));
        end

        // Long random run against the pixel-order model.
        written = 0;
        while (written < 10000) begin
            wr = ($urandom_range(0, 99) < 35);
            di = {16'($urandom), 32'($urandom)};
            pready = ($urandom_range(0, 99) < 75);
            if (wr) written++;
            step();
        end
        drain("random_drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
